// File: rtl/osd_him_gearbox.sv
// Host interface bridge between a GLIP byte-stream channel (16 or 32 bit) and the DII debug NoC.
// Optional statistics counters are built when the macro OSD_HIM_STATS_EN is defined.
module osd_him_gearbox #(
    parameter int unsigned GLIP_WIDTH  = 16,
    parameter int unsigned BUF_SIZE    = 8,
    parameter int unsigned MAX_ING_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [GLIP_WIDTH-1:0] glip_in_data,
    input  logic                  glip_in_valid,
    output logic                  glip_in_ready,
    output logic [GLIP_WIDTH-1:0] glip_out_data,
    output logic                  glip_out_valid,
    input  logic                  glip_out_ready,
    output logic [15:0]           dii_out_data,
    output logic                  dii_out_valid,
    output logic                  dii_out_last,
    input  logic                  dii_out_ready,
    input  logic [15:0]           dii_in_data,
    input  logic                  dii_in_valid,
    input  logic                  dii_in_last,
    output logic                  dii_in_ready,
    output logic [15:0]           stat_ing_pkts,
    output logic [15:0]           stat_ing_drop,
    output logic [15:0]           stat_egr_pkts
);
    localparam int unsigned PtrW = $clog2(BUF_SIZE);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [15:0] MaxIngLen = 16'(MAX_ING_LEN);

    function automatic logic [15:0] swap16(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    typedef enum logic [1:0] {StIdle, StFwd, StDrop} ing_state_e;
    typedef enum logic {StHdr, StData} egr_state_e;

    ing_state_e  ing_state_q;
    egr_state_e  egr_state_q;
    logic [15:0] rem_q;
    logic [15:0] iw_data, ew_data;
    logic        iw_valid, iw_ready, iw_take;
    logic        ew_valid, ew_last, ew_take;

    // Ingress word stream: FWD consumes only when the NoC accepts, IDLE/DROP always consume.
    assign iw_ready = (ing_state_q != StFwd) || dii_out_ready;
    assign iw_take  = iw_valid && iw_ready;

    if (GLIP_WIDTH == 32) begin : g_unpack32
        logic [31:0] beat_q;
        logic        full_q, upper_q;

        assign iw_valid      = full_q;
        assign iw_data       = swap16(upper_q ? beat_q[31:16] : beat_q[15:0]);
        assign glip_in_ready = !full_q || (upper_q && iw_ready);

        always_ff @(posedge clk) begin
            if (rst) begin
                full_q  <= 1'b0;
                upper_q <= 1'b0;
                beat_q  <= '0;
            end else if (glip_in_ready && glip_in_valid) begin
                full_q  <= 1'b1;
                upper_q <= 1'b0;
                beat_q  <= glip_in_data;
            end else if (iw_take) begin
                if (upper_q) full_q <= 1'b0;
                upper_q <= !upper_q;
            end
        end
    end else begin : g_unpack16
        assign iw_valid      = glip_in_valid;
        assign iw_data       = swap16(glip_in_data);
        assign glip_in_ready = iw_ready;
    end

    assign dii_out_valid = (ing_state_q == StFwd) && iw_valid;
    assign dii_out_data  = iw_data;
    assign dii_out_last  = dii_out_valid && (rem_q == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ing_state_q <= StIdle;
            rem_q       <= '0;
        end else if (iw_take) begin
            unique case (ing_state_q)
                StIdle: begin
                    if (iw_data != 16'd0) begin
                        rem_q       <= iw_data - 16'd1;
                        ing_state_q <= (iw_data > MaxIngLen) ? StDrop : StFwd;
                    end
                end
                StFwd, StDrop: begin
                    if (rem_q == 16'd0) ing_state_q <= StIdle;
                    else                rem_q <= rem_q - 16'd1;
                end
                default: ing_state_q <= StIdle;
            endcase
        end
    end

    // Egress full-packet buffer: flit FIFO plus a FIFO of completed packet sizes.
    logic [16:0]     buf_mem  [BUF_SIZE];
    logic [CntW-1:0] size_mem [BUF_SIZE];
    logic [PtrW-1:0] buf_wr_q, buf_rd_q, size_wr_q, size_rd_q;
    logic [CntW-1:0] buf_cnt_q, pkt_cnt_q, acc_q;
    logic [16:0]     buf_head;
    logic            buf_push, buf_pop, size_push, size_pop;

    assign dii_in_ready = !rst && (buf_cnt_q != CntW'(BUF_SIZE));
    assign buf_push     = dii_in_valid && dii_in_ready;
    assign size_push    = buf_push && dii_in_last;
    assign buf_pop      = ew_take && (egr_state_q == StData);
    assign size_pop     = ew_take && (egr_state_q == StHdr);
    assign buf_head     = buf_mem[buf_rd_q];

    always_ff @(posedge clk) begin
        if (buf_push)  buf_mem[buf_wr_q]   <= {dii_in_last, dii_in_data};
        if (size_push) size_mem[size_wr_q] <= acc_q + CntW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_wr_q  <= '0;
            buf_rd_q  <= '0;
            size_wr_q <= '0;
            size_rd_q <= '0;
            buf_cnt_q <= '0;
            pkt_cnt_q <= '0;
            acc_q     <= '0;
        end else begin
            if (buf_push) begin
                buf_wr_q <= buf_wr_q + PtrW'(1);
                acc_q    <= dii_in_last ? '0 : acc_q + CntW'(1);
            end
            if (buf_pop)   buf_rd_q  <= buf_rd_q + PtrW'(1);
            if (size_push) size_wr_q <= size_wr_q + PtrW'(1);
            if (size_pop)  size_rd_q <= size_rd_q + PtrW'(1);
            buf_cnt_q <= buf_cnt_q + CntW'(buf_push) - CntW'(buf_pop);
            pkt_cnt_q <= pkt_cnt_q + CntW'(size_push) - CntW'(size_pop);
        end
    end

    assign ew_valid = (egr_state_q == StHdr) ? (pkt_cnt_q != '0) : (buf_cnt_q != '0);
    assign ew_data  = (egr_state_q == StHdr) ? 16'(size_mem[size_rd_q]) : buf_head[15:0];
    assign ew_last  = (egr_state_q == StData) && buf_head[16];

    always_ff @(posedge clk) begin
        if (rst) begin
            egr_state_q <= StHdr;
        end else if (ew_take) begin
            if (egr_state_q == StHdr) egr_state_q <= StData;
            else if (ew_last)         egr_state_q <= StHdr;
        end
    end

    if (GLIP_WIDTH == 32) begin : g_pack32
        logic [15:0] lo_q;
        logic        lo_full_q;
        logic [31:0] out_q;
        logic        out_valid_q;
        logic        out_free;

        // An odd final word goes straight out with a zero pad so packets never straddle beats.
        assign out_free       = !out_valid_q || glip_out_ready;
        assign ew_take        = ew_valid && ((lo_full_q || ew_last) ? out_free : 1'b1);
        assign glip_out_valid = out_valid_q;
        assign glip_out_data  = out_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                lo_q        <= '0;
                lo_full_q   <= 1'b0;
                out_q       <= '0;
                out_valid_q <= 1'b0;
            end else begin
                if (out_valid_q && glip_out_ready) out_valid_q <= 1'b0;
                if (ew_take) begin
                    if (lo_full_q) begin
                        out_q       <= {swap16(ew_data), lo_q};
                        out_valid_q <= 1'b1;
                        lo_full_q   <= 1'b0;
                    end else if (ew_last) begin
                        out_q       <= {16'h0000, swap16(ew_data)};
                        out_valid_q <= 1'b1;
                    end else begin
                        lo_q      <= swap16(ew_data);
                        lo_full_q <= 1'b1;
                    end
                end
            end
        end
    end else begin : g_pack16
        assign ew_take        = ew_valid && glip_out_ready;
        assign glip_out_valid = ew_valid;
        assign glip_out_data  = swap16(ew_data);
    end

`ifdef OSD_HIM_STATS_EN
    logic [15:0] ing_pkts_q, ing_drop_q, egr_pkts_q;
    logic        ing_done, ing_drop, egr_done;

    assign ing_done = iw_take && (ing_state_q == StFwd) && (rem_q == 16'd0);
    assign ing_drop = iw_take && (ing_state_q == StIdle) && (iw_data > MaxIngLen);
    assign egr_done = buf_pop && ew_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            ing_pkts_q <= '0;
            ing_drop_q <= '0;
            egr_pkts_q <= '0;
        end else begin
            if (ing_done) ing_pkts_q <= ing_pkts_q + 16'd1;
            if (ing_drop) ing_drop_q <= ing_drop_q + 16'd1;
            if (egr_done) egr_pkts_q <= egr_pkts_q + 16'd1;
        end
    end

    assign stat_ing_pkts = ing_pkts_q;
    assign stat_ing_drop = ing_drop_q;
    assign stat_egr_pkts = egr_pkts_q;
`else
    assign stat_ing_pkts = '0;
    assign stat_ing_drop = '0;
    assign stat_egr_pkts = '0;
`endif

endmodule

// File: tb/tb_osd_him_gearbox.sv
// Bench for osd_him_gearbox: a 16-bit and a 32-bit instance driven with directed vectors.
module tb_osd_him_gearbox;
`ifdef OSD_HIM_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // a_*: GLIP_WIDTH=16 instance, b_*: GLIP_WIDTH=32 instance
    logic [15:0] a_gin_data = '0, a_gout_data;
    logic        a_gin_valid = 1'b0, a_gin_ready, a_gout_valid, a_gout_ready = 1'b1;
    logic [15:0] a_dout_data, a_din_data = '0;
    logic        a_dout_valid, a_dout_last, a_dout_ready = 1'b1;
    logic        a_din_valid = 1'b0, a_din_last = 1'b0, a_din_ready;
    logic [15:0] a_s_ip, a_s_id, a_s_ep;

    logic [31:0] b_gin_data = '0, b_gout_data;
    logic        b_gin_valid = 1'b0, b_gin_ready, b_gout_valid, b_gout_ready = 1'b1;
    logic [15:0] b_dout_data, b_din_data = '0;
    logic        b_dout_valid, b_dout_last, b_dout_ready = 1'b1;
    logic        b_din_valid = 1'b0, b_din_last = 1'b0, b_din_ready;
    logic [15:0] b_s_ip, b_s_id, b_s_ep;

    osd_him_gearbox #(.GLIP_WIDTH(16), .BUF_SIZE(8), .MAX_ING_LEN(32)) u_a (
        .clk(clk), .rst(rst),
        .glip_in_data(a_gin_data), .glip_in_valid(a_gin_valid), .glip_in_ready(a_gin_ready),
        .glip_out_data(a_gout_data), .glip_out_valid(a_gout_valid),
        .glip_out_ready(a_gout_ready),
        .dii_out_data(a_dout_data), .dii_out_valid(a_dout_valid), .dii_out_last(a_dout_last),
        .dii_out_ready(a_dout_ready),
        .dii_in_data(a_din_data), .dii_in_valid(a_din_valid), .dii_in_last(a_din_last),
        .dii_in_ready(a_din_ready),
        .stat_ing_pkts(a_s_ip), .stat_ing_drop(a_s_id), .stat_egr_pkts(a_s_ep)
    );

    osd_him_gearbox #(.GLIP_WIDTH(32), .BUF_SIZE(8), .MAX_ING_LEN(32)) u_b (
        .clk(clk), .rst(rst),
        .glip_in_data(b_gin_data), .glip_in_valid(b_gin_valid), .glip_in_ready(b_gin_ready),
        .glip_out_data(b_gout_data), .glip_out_valid(b_gout_valid),
        .glip_out_ready(b_gout_ready),
        .dii_out_data(b_dout_data), .dii_out_valid(b_dout_valid), .dii_out_last(b_dout_last),
        .dii_out_ready(b_dout_ready),
        .dii_in_data(b_din_data), .dii_in_valid(b_din_valid), .dii_in_last(b_din_last),
        .dii_in_ready(b_din_ready),
        .stat_ing_pkts(b_s_ip), .stat_ing_drop(b_s_id), .stat_egr_pkts(b_s_ep)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [16:0] a_fq[$];
    logic [15:0] a_gq[$];
    logic [31:0] b_gq[$];

    always @(posedge clk) begin
        if (a_dout_valid && a_dout_ready) a_fq.push_back({a_dout_last, a_dout_data});
        if (a_gout_valid && a_gout_ready) a_gq.push_back(a_gout_data);
        if (b_gout_valid && b_gout_ready) b_gq.push_back(b_gout_data);
    end

    function automatic logic [15:0] sw(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    function automatic logic [15:0] st(input int n);
        return StatsEn ? 16'(n) : 16'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic gin16(input logic [15:0] w);
        logic ok = 1'b0;
        @(negedge clk);
        a_gin_valid = 1'b1;
        a_gin_data  = sw(w);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            ok = a_gin_ready;
        end
        check("gin16_handshake", ok, 1);
    endtask

    task automatic din_a(input logic [15:0] d, input logic l);
        logic ok = 1'b0;
        @(negedge clk);
        a_din_valid = 1'b1; a_din_data = d; a_din_last = l;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            ok = a_din_ready;
        end
        check("din_a_handshake", ok, 1);
        @(negedge clk);
        a_din_valid = 1'b0;
    endtask

    task automatic din_b(input logic [15:0] d, input logic l);
        logic ok = 1'b0;
        @(negedge clk);
        b_din_valid = 1'b1; b_din_data = d; b_din_last = l;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            ok = b_din_ready;
        end
        check("din_b_handshake", ok, 1);
        @(negedge clk);
        b_din_valid = 1'b0;
    endtask

    typedef struct packed {
        logic        v;
        logic [15:0] w;
        logic        dr;
        logic        ev;
        logic [15:0] ed;
        logic        el;
        logic        er;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // {glip valid, logical word, dii_out_ready, exp valid, exp data, exp last, exp glip ready}
        vecs[0] = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 16'h0003, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 16'h12A0, 1'b1, 1'b1, 16'h12A0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 16'hB0B1, 1'b0, 1'b1, 16'hB0B1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'hB0B1, 1'b1, 1'b1, 16'hB0B1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 16'hC0C1, 1'b1, 1'b1, 16'hC0C1, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 16'h5A5A, 1'b0, 1'b1, 16'h5A5A, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 16'h5A5A, 1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_a_din_ready", a_din_ready, 0);
        check("rst_b_din_ready", b_din_ready, 0);
        check("rst_a_dout_valid", a_dout_valid, 0);
        check("rst_b_gout_valid", b_gout_valid, 0);
        check("rst_a_gout_valid", a_gout_valid, 0);
        check("rst_a_stats", {a_s_ip, a_s_id}, 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_a_din_ready", a_din_ready, 1);
        check("post_rst_b_gin_ready", b_gin_ready, 1);

        // 16-bit ingress vectors
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_gin_valid  = vecs[i].v;
            a_gin_data   = sw(vecs[i].w);
            a_dout_ready = vecs[i].dr;
            #1;
            check($sformatf("vec%0d_valid", i), a_dout_valid, vecs[i].ev);
            check($sformatf("vec%0d_gready", i), a_gin_ready, vecs[i].er);
            if (vecs[i].ev) begin
                check($sformatf("vec%0d_data", i), a_dout_data, vecs[i].ed);
                check($sformatf("vec%0d_last", i), a_dout_last, vecs[i].el);
            end
        end
        @(negedge clk);
        a_gin_valid  = 1'b0;
        a_dout_ready = 1'b1;
        #1;
        check("stat_ing_pkts_2", a_s_ip, st(2));

        // Oversize drop then a forwarded 1-flit packet
        a_fq.delete();
        gin16(16'h0028);
        for (int i = 0; i < 40; i++) gin16(16'(i + 16'h0100));
        @(negedge clk); a_gin_valid = 1'b0;
        check("drop_no_flits", a_fq.size(), 0);
        check("stat_ing_drop_1", a_s_id, st(1));
        gin16(16'h0001);
        gin16(16'h7777);
        @(negedge clk); a_gin_valid = 1'b0;
        @(negedge clk);
        check("after_drop_nflits", a_fq.size(), 1);
        if (a_fq.size() == 1) check("after_drop_flit", a_fq[0], {1'b1, 16'h7777});
        check("stat_ing_pkts_3", a_s_ip, st(3));

        // 32-bit ingress, cycle exact
        @(negedge clk);
        b_gin_valid = 1'b1;
        b_gin_data  = {sw(16'h0002), sw(16'h0000)};
        #1; check("w32_rdy_empty", b_gin_ready, 1);
        @(negedge clk);
        b_gin_data = {sw(16'h2222), sw(16'h1111)};
        #1; check("w32_rdy_lower", b_gin_ready, 0);
        check("w32_pad_noflit", b_dout_valid, 0);
        @(negedge clk); #1;
        check("w32_rdy_upper", b_gin_ready, 1);
        check("w32_len_noflit", b_dout_valid, 0);
        @(negedge clk);
        b_gin_valid = 1'b0;
        #1; check("w32_rdy_f1", b_gin_ready, 0);
        check("w32_f1", {b_dout_valid, b_dout_last, b_dout_data}, {2'b10, 16'h1111});
        @(negedge clk); #1;
        check("w32_rdy_f2", b_gin_ready, 1);
        check("w32_f2", {b_dout_valid, b_dout_last, b_dout_data}, {2'b11, 16'h2222});
        @(negedge clk); #1;
        check("w32_idle", b_dout_valid, 0);

        // 32-bit egress with pad, then backpressure hold
        din_b(16'hABCD, 1'b0);
        din_b(16'h1234, 1'b1);
        repeat (10) @(negedge clk);
        check("egr32_nbeats_2", b_gq.size(), 2);
        if (b_gq.size() == 2) begin
            check("egr32_beat0", b_gq[0], {sw(16'hABCD), sw(16'h0002)});
            check("egr32_beat1", b_gq[1], {16'h0000, sw(16'h1234)});
        end
        b_gout_ready = 1'b0;
        din_b(16'h5EE5, 1'b1);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk); #1;
                seen = b_gout_valid;
            end
            check("egr32_z_valid", seen, 1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check($sformatf("egr32_hold%0d", i), {b_gout_valid, b_gout_data},
                  {1'b1, sw(16'h5EE5), sw(16'h0001)});
        end
        b_gout_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("egr32_nbeats_3", b_gq.size(), 3);
        check("stat_egr_pkts_b", b_s_ep, st(2));

        // 16-bit egress, no pad
        din_a(16'h0102, 1'b0);
        din_a(16'h0304, 1'b1);
        repeat (8) @(negedge clk);
        check("egr16_nwords", a_gq.size(), 3);
        if (a_gq.size() == 3) begin
            check("egr16_w0", a_gq[0], sw(16'h0002));
            check("egr16_w1", a_gq[1], sw(16'h0102));
            check("egr16_w2", a_gq[2], sw(16'h0304));
        end

        // dii_out_ready toggling: no loss, no duplication
        a_fq.delete();
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    @(negedge clk);
                    a_dout_ready = ~a_dout_ready;
                end
                @(negedge clk);
                a_dout_ready = 1'b1;
            end
            begin
                gin16(16'h0004);
                for (int i = 1; i <= 4; i++) gin16(16'(16'hF000 + i));
                @(negedge clk);
                a_gin_valid = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check("bp_nflits", a_fq.size(), 4);
        if (a_fq.size() == 4)
            for (int i = 0; i < 4; i++)
                check($sformatf("bp_flit%0d", i), a_fq[i], {i == 3, 16'(16'hF000 + i + 1)});

        // Reset mid-FWD with rem=2
        gin16(16'h0004);
        gin16(16'h0AA1);
        @(negedge clk);
        a_gin_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_din_ready", a_din_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        a_fq.delete();
        #1;
        check("mid_rst_stats", {a_s_ip, a_s_ep}, 32'h0);
        check("mid_rst_gout_valid", a_gout_valid, 0);
        @(negedge clk);
        a_gin_valid = 1'b1;
        a_gin_data  = sw(16'h0001);
        #1;
        check("mid_rst_len_noflit", a_dout_valid, 0);
        @(posedge clk);
        gin16(16'h4444);
        @(negedge clk);
        a_gin_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_nflits", a_fq.size(), 1);
        if (a_fq.size() == 1) check("mid_rst_flit", a_fq[0], {1'b1, 16'h4444});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
